grf_mp: RTL and testbench
=========================

Name: grf_mp

Overview:
- Parametrised multi-port general register file for the next-generation pipelined/dual-issue core.
- Provides NR combinational read ports and two prioritised write ports, with write-to-read bypass.
- Adds a per-register busy scoreboard: set at issue, cleared at writeback. Hazard logic reads busy state alongside data.
- Sits between decode (read/issue) and writeback (write/clear).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NR, 2, number of read ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and is never marked busy.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- WE0  in  1  write enable, port 0.
- WA0  in  AW  write address, port 0.
- WD0  in  DW  write data, port 0.
- WE1  in  1  write enable, port 1 (higher priority).
- WA1  in  AW  write address, port 1.
- WD1  in  DW  write data, port 1.
- RA  in  NR*AW  read addresses, flattened; port k = bits [k*AW +: AW].
- RD  out  NR*DW  read data, flattened; port k = bits [k*DW +: DW].
- RBUSY  out  NR  busy flag for each read address.
- SET_EN  in  1  issue: mark register SET_A busy.
- SET_A  in  AW  register to mark busy.
- BUSY_CNT  out  AW+1  number of registers currently busy (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers go to 0, all busy bits to 0, and BUSY_CNT to 0 immediately.
  - Any write or SET in that cycle is discarded.
  - On deassertion, normal operation resumes at the next rising edge.
- Write (posedge):
  - If WEi=1 and the target is not the zero register, reg[WAi] <= WDi and busy[WAi] is cleared.
  - If WE0 and WE1 target the same address, WD1 is stored (port 1 wins).
  - Different addresses are both written in the same cycle.
- Zero register (ZERO_REG=1):
  - Writes and SETs to address 0 are ignored.
  - Reads of address 0 return 0 and RBUSY=0, overriding bypass.
- Read (combinational, zero latency), per port k, in priority order:
  1. Zero-register rule.
  2. WE1 && WA1==RA_k gives WD1.
  3. WE0 && WA0==RA_k gives WD0.
  4. Otherwise reg[RA_k].
- RBUSY_k: busy[RA_k] with the same-cycle clear folded in.
  - It is 0 if a write this cycle targets RA_k.
  - A same-cycle SET to RA_k does NOT raise RBUSY (it becomes visible next cycle).
- Scoreboard (posedge):
  - SET_EN sets busy[SET_A].
  - If a SET and a write clear hit the same register in one cycle, SET wins and the register stays busy (the new producer supersedes the old one); the write data is still stored.
  - SET on an already-busy register leaves it busy, with no count change.
  - A write to a non-busy register is legal and leaves it non-busy.
- BUSY_CNT:
  - Registered population count of the busy vector; updates one cycle after the set/clear edge.
  - Maximum value is 2**AW - ZERO_REG, so it never wraps.
- X/undefined addresses are not supported. Parameter checks: NR>=1, AW>=1.

Decomposition:
- Shared package/header `grf_defs`:
  - default DW/AW;
  - the ZERO_ADDR constant;
  - a slice macro/function for flattened port indexing.
- One natural sub-module, `grf_scoreboard`: busy vector, set/clear priority, and the BUSY_CNT register. Bypass and storage stay in the top level.

Test Plan:
1. Reset mid-operation:
   - Write 0xDEADBEEF to r5 and SET r6, then pull reset low between edges.
   - Expect RD(r5)=0, RBUSY(r6)=0 and BUSY_CNT=0 without any clock edge.
2. Dual-write collision:
   - WE0 r3=0x11111111 and WE1 r3=0x22222222 in the same cycle.
   - Same cycle: RD(r3)=0x22222222. Next cycle, with no write: RD(r3)=0x22222222.
3. Bypass:
   - Read r7 while WE0 writes r7=0xA5A5A5A5.
   - Expect RD=0xA5A5A5A5 in the same cycle; the other read port reading r8 returns the old r8.
4. Scoreboard:
   - SET r4 at cycle n: RBUSY(r4)=0 at n, 1 at n+1, and BUSY_CNT=1 at n+2.
   - WE1 write to r4 at n+3: RBUSY(r4)=0 at n+3 and BUSY_CNT=0 at n+5.
5. Set/clear collision:
   - r9 busy, then SET r9 and WE0 r9=0x5 in the same cycle.
   - Next cycle: RD(r9)=0x5, RBUSY(r9)=1, BUSY_CNT unchanged.
6. Zero register:
   - WE1 r0=0xFFFFFFFF and SET r0.
   - Expect RD(r0)=0 and RBUSY(r0)=0 always, with BUSY_CNT unchanged. Also repeat tests 2–3 with NR=4 and DW=64.

Source files
------------

// File: rtl/grf_defs.sv
// Shared definitions for the multi-port register file: default widths,
// the hardwired-zero address and the flattened-port slice helper.
package grf_defs;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 5;
  localparam int ZERO_ADDR = 0;

  // Lowest bit of element k in a flattened vector of w-bit elements.
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, with a
// registered population count of the busy vector.
module grf_scoreboard
  import grf_defs::*;
#(
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_a,
  input  logic                 clr0_en,
  input  logic [AW-1:0]        clr0_a,
  input  logic                 clr1_en,
  input  logic [AW-1:0]        clr1_a,
  output logic [(1<<AW)-1:0]   busy,
  output logic [AW:0]          busy_cnt
);

  localparam int DEPTH = 1 << AW;

  logic             set_ok;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      pop;

  assign set_ok = set_en && !((ZERO_REG != 0) && (set_a == AW'(ZERO_ADDR)));

  // Set is applied last: a new producer supersedes a retiring one.
  always_comb begin
    busy_next = busy;
    if (clr0_en) busy_next[clr0_a] = 1'b0;
    if (clr1_en) busy_next[clr1_a] = 1'b0;
    if (set_ok)  busy_next[set_a]  = 1'b1;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop = pop + {{AW{1'b0}}, busy[i]};
    end
  end

  // The count tracks the current busy vector, so it lags set/clear by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= pop;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file: NR combinational read ports with
// write-to-read bypass, two prioritised write ports and a busy scoreboard.
module grf_mp
  import grf_defs::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WE0,
  input  logic [AW-1:0]   WA0,
  input  logic [DW-1:0]   WD0,
  input  logic            WE1,
  input  logic [AW-1:0]   WA1,
  input  logic [DW-1:0]   WD1,
  input  logic [NR*AW-1:0] RA,
  output logic [NR*DW-1:0] RD,
  output logic [NR-1:0]   RBUSY,
  input  logic            SET_EN,
  input  logic [AW-1:0]   SET_A,
  output logic [AW:0]     BUSY_CNT
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZA    = AW'(ZERO_ADDR);
  localparam bit            HAS_Z = (ZERO_REG != 0);

  if (NR < 1 || AW < 1) begin : g_param_err
    $error("grf_mp: NR and AW must both be at least 1");
  end

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr0_ok;
  logic             wr1_ok;

  assign wr0_ok = WE0 && !(HAS_Z && (WA0 == ZA));
  assign wr1_ok = WE1 && !(HAS_Z && (WA1 == ZA));

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr0_ok) mem[WA0] <= WD0;
      if (wr1_ok) mem[WA1] <= WD1;
    end
  end

  grf_scoreboard #(
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (SET_EN),
    .set_a    (SET_A),
    .clr0_en  (wr0_ok),
    .clr0_a   (WA0),
    .clr1_en  (wr1_ok),
    .clr1_a   (WA1),
    .busy     (busy),
    .busy_cnt (BUSY_CNT)
  );

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          bsy;

    assign ra = RA[slice_lsb(gi, AW) +: AW];

    // Later assignments have higher priority; a same-cycle SET is not bypassed.
    always_comb begin
      rd  = mem[ra];
      bsy = busy[ra];
      if (WE0 && (WA0 == ra)) begin
        rd  = WD0;
        bsy = 1'b0;
      end
      if (WE1 && (WA1 == ra)) begin
        rd  = WD1;
        bsy = 1'b0;
      end
      if (HAS_Z && (ra == ZA)) begin
        rd  = '0;
        bsy = 1'b0;
      end
    end

    assign RD[slice_lsb(gi, DW) +: DW] = rd;
    assign RBUSY[gi]                   = bsy;
  end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model; a wide 4-port instance too.
module tb_grf_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          we0 = 0, we1 = 0, set_en = 0;
  logic [AW-1:0] wa0 = 0, wa1 = 0, set_a = 0;
  logic [DW-1:0] wd0 = 0, wd1 = 0;
  logic [NR*AW-1:0] ra = 0;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rbusy;
  logic [AW:0]      busy_cnt;

  grf_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset),
    .WE0(we0), .WA0(wa0), .WD0(wd0),
    .WE1(we1), .WA1(wa1), .WD1(wd1),
    .RA(ra), .RD(rd), .RBUSY(rbusy),
    .SET_EN(set_en), .SET_A(set_a), .BUSY_CNT(busy_cnt)
  );

  // Wide variant: four read ports, 64-bit data
  logic          w_we0 = 0, w_we1 = 0, w_set_en = 0;
  logic [4:0]    w_wa0 = 0, w_wa1 = 0, w_set_a = 0;
  logic [63:0]   w_wd0 = 0, w_wd1 = 0;
  logic [19:0]   w_ra = 0;
  logic [255:0]  w_rd;
  logic [3:0]    w_rbusy;
  logic [5:0]    w_busy_cnt;

  grf_mp #(.DW(64), .AW(5), .NR(4), .ZERO_REG(1)) u_wide (
    .clk(clk), .reset(reset),
    .WE0(w_we0), .WA0(w_wa0), .WD0(w_wd0),
    .WE1(w_we1), .WA1(w_wa1), .WD1(w_wd1),
    .RA(w_ra), .RD(w_rd), .RBUSY(w_rbusy),
    .SET_EN(w_set_en), .SET_A(w_set_a), .BUSY_CNT(w_busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register values, busy flags and the
  // population count observed one cycle earlier.
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];
  int            m_last_pop;

  logic [DW-1:0] s_rd0, s_rd1;
  logic [NR-1:0] s_rb;
  logic [AW:0]   s_cnt;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 0;
    end
    m_last_pop = 0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if ((we1 && wa1 == a) || (we0 && wa0 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void model_edge();
    int pop = 0;
    for (int i = 0; i < DEPTH; i++) pop += int'(m_busy[i]);
    m_last_pop = pop;
    if (we0 && wa0 != 0) begin m_reg[wa0] = wd0; m_busy[wa0] = 0; end
    if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_busy[wa1] = 0; end
    if (set_en && set_a != 0) m_busy[set_a] = 1;
  endfunction

  task automatic step(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic se, input logic [AW-1:0] sa,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    @(negedge clk);
    we0 = e0; wa0 = a0; wd0 = d0;
    we1 = e1; wa1 = a1; wd1 = d1;
    set_en = se; set_a = sa;
    ra = {r1, r0};
    #1;
    s_rd0 = rd[31:0];
    s_rd1 = rd[63:32];
    s_rb  = rbusy;
    s_cnt = busy_cnt;
    check("rd0", 64'(s_rd0), 64'(exp_rd(r0)));
    check("rd1", 64'(s_rd1), 64'(exp_rd(r1)));
    check("rbusy0", 64'(s_rb[0]), 64'(exp_busy(r0)));
    check("rbusy1", 64'(s_rb[1]), 64'(exp_busy(r1)));
    check("busy_cnt", 64'(s_cnt), 64'(m_last_pop));
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  int cnt_before;

  initial begin
    model_reset();
    ra = {5'd6, 5'd5};
    #3;
    check("reset_rd", 64'(rd), 64'd0);
    check("reset_rbusy", 64'(rbusy), 64'd0);
    check("reset_cnt", 64'(busy_cnt), 64'd0);
    #9 reset = 1'b1;

    // 1: reset mid-operation, plus a write held during reset is discarded
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 6, 5, 6);
    idle(5, 6);
    check("t1_pre_rd5", 64'(s_rd0), 64'hDEADBEEF);
    check("t1_pre_busy6", 64'(s_rb[1]), 64'd1);
    @(negedge clk);
    we0 = 1; wa0 = 10; wd0 = 32'h12345678;
    set_en = 1; set_a = 11;
    ra = {5'd6, 5'd5};
    #2 reset = 1'b0;
    #1;
    check("t1_rst_rd5", 64'(rd[31:0]), 64'd0);
    check("t1_rst_busy6", 64'(rbusy[1]), 64'd0);
    check("t1_rst_cnt", 64'(busy_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    we0 = 0; set_en = 0;
    #2 reset = 1'b1;
    idle(10, 11);
    check("t1_discard_rd10", 64'(s_rd0), 64'd0);
    check("t1_discard_busy11", 64'(s_rb[1]), 64'd0);

    // 2: dual-write collision
    step(1, 3, 32'h11111111, 1, 3, 32'h22222222, 0, 0, 3, 3);
    check("t2_same_cycle", 64'(s_rd0), 64'h22222222);
    idle(3, 3);
    check("t2_next_cycle", 64'(s_rd1), 64'h22222222);

    // 3: bypass, other port sees the old r8
    step(1, 8, 32'h88888888, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 7, 8);
    check("t3_bypass", 64'(s_rd0), 64'hA5A5A5A5);
    check("t3_other", 64'(s_rd1), 64'h88888888);

    // 4: scoreboard timing
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    check("t4_busy_n", 64'(s_rb[0]), 64'd0);
    idle(4, 0);
    check("t4_busy_n1", 64'(s_rb[0]), 64'd1);
    idle(4, 0);
    check("t4_cnt_n2", 64'(s_cnt), 64'd1);
    step(0, 0, 0, 1, 4, 32'h44, 0, 0, 4, 0);
    check("t4_busy_n3", 64'(s_rb[0]), 64'd0);
    idle(4, 0);
    idle(4, 0);
    check("t4_cnt_n5", 64'(s_cnt), 64'd0);

    // 5: set/clear collision keeps the register busy
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(9, 0);
    idle(9, 0);
    cnt_before = int'(s_cnt);
    step(1, 9, 32'h5, 0, 0, 0, 1, 9, 9, 0);
    idle(9, 0);
    check("t5_rd9", 64'(s_rd0), 64'h5);
    check("t5_busy9", 64'(s_rb[0]), 64'd1);
    idle(9, 0);
    check("t5_cnt", 64'(s_cnt), 64'(cnt_before));

    // 6: zero register
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    check("t6_rd0_same", 64'(s_rd0), 64'd0);
    check("t6_busy0_same", 64'(s_rb[0]), 64'd0);
    idle(0, 9);
    idle(0, 9);
    check("t6_rd0_next", 64'(s_rd0), 64'd0);
    check("t6_busy0_next", 64'(s_rb[0]), 64'd0);
    check("t6_cnt", 64'(s_cnt), 64'(cnt_before));

    // Randomized traffic with frequent address collisions
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
           1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
           1'($urandom_range(0, 2) == 0), rnd_addr(),
           rnd_addr(), rnd_addr());
    end

    // Wide instance: collision and bypass across four ports
    @(negedge clk);
    w_we0 = 1; w_wa0 = 8; w_wd0 = 64'h0123456789ABCDEF;
    @(negedge clk);
    w_we0 = 1; w_wa0 = 3; w_wd0 = 64'h1111111111111111;
    w_we1 = 1; w_wa1 = 3; w_wd1 = 64'h2222222222222222;
    w_ra = {5'd0, 5'd8, 5'd3, 5'd3};
    #1;
    check("w_coll_p0", w_rd[0 +: 64], 64'h2222222222222222);
    check("w_coll_p1", w_rd[64 +: 64], 64'h2222222222222222);
    check("w_old_r8", w_rd[128 +: 64], 64'h0123456789ABCDEF);
    check("w_zero", w_rd[192 +: 64], 64'd0);
    @(negedge clk);
    w_we0 = 0; w_we1 = 0;
    #1;
    check("w_coll_next", w_rd[0 +: 64], 64'h2222222222222222);
    @(negedge clk);
    w_we0 = 1; w_wa0 = 7; w_wd0 = 64'hA5A5A5A5A5A5A5A5;
    w_ra = {5'd8, 5'd7, 5'd8, 5'd7};
    #1;
    check("w_bypass_p0", w_rd[0 +: 64], 64'hA5A5A5A5A5A5A5A5);
    check("w_other_p1", w_rd[64 +: 64], 64'h0123456789ABCDEF);
    check("w_bypass_p2", w_rd[128 +: 64], 64'hA5A5A5A5A5A5A5A5);
    check("w_other_p3", w_rd[192 +: 64], 64'h0123456789ABCDEF);
    check("w_rbusy", 64'(w_rbusy), 64'd0);
    check("w_cnt", 64'(w_busy_cnt), 64'd0);
    @(negedge clk);
    w_we0 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
